// File: rtl/int_gateway_claim.sv
// int_gateway_claim
//   Receiving end of the flattened interrupt vector from the interrupt xbar.
//   Each level-sensitive source is synchronized and passed through a small
//   gateway (IDLE / PENDING / INFLIGHT). The enabled pending sources are
//   aggregated into one registered irq. A claim/complete port on the hart
//   side services them, and the lowest source index wins. Source i is
//   reported as ID i+1, and ID 0 means "no interrupt".
//
// Ports
//   clock            in   sole clock
//   reset            in   asynchronous, active-high reset
//   int_in           in   level interrupt vector, may be asynchronous
//   int_enable       in   per-source enable mask, synchronous to clock
//   irq_out          out  registered: any source pending and enabled
//   claim_req        in   one-cycle claim strobe
//   claim_resp_valid out  one-cycle response pulse, the cycle after claim_req
//   claim_resp_id    out  claimed ID (0 = nothing claimable), held until next claim
//   complete_valid   in   one-cycle completion strobe
//   complete_id      in   ID being completed
//   dbg_state        out  gateway state of every source, 2 bits per source
//
// Handshake: claim_req is a request-only strobe with no ready. Every cycle
// with claim_req=1 produces exactly one claim_resp_valid pulse on the next
// edge. complete_valid is likewise a fire-and-forget strobe.
module int_gateway_claim #(
    parameter int NUM_SRC     = 5,
    parameter int SYNC_STAGES = 2,
    parameter int ID_W        = 3
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_SRC-1:0]   int_in,
    input  logic [NUM_SRC-1:0]   int_enable,
    output logic                 irq_out,
    input  logic                 claim_req,
    output logic                 claim_resp_valid,
    output logic [ID_W-1:0]      claim_resp_id,
    input  logic                 complete_valid,
    input  logic [ID_W-1:0]      complete_id,
    output logic [2*NUM_SRC-1:0] dbg_state
);

    typedef enum logic [1:0] {
        GW_IDLE     = 2'd0,
        GW_PENDING  = 2'd1,
        GW_INFLIGHT = 2'd2
    } gw_state_e;

    gw_state_e          state_q [NUM_SRC];
    gw_state_e          state_d [NUM_SRC];
    logic [NUM_SRC-1:0] sync_q  [SYNC_STAGES];
    logic [NUM_SRC-1:0] s_lvl;
    logic [NUM_SRC-1:0] eligible;
    logic [NUM_SRC-1:0] complete_hit;
    logic [ID_W-1:0]    sel_id;
    logic               irq_q, irq_d;
    logic               resp_valid_q, resp_valid_d;
    logic [ID_W-1:0]    resp_id_q, resp_id_d;

    // Synchronizer chain. Level semantics only, so there is no edge detect.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            sync_q[0] <= int_in;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign s_lvl = sync_q[SYNC_STAGES-1];

    // Arbitration and completion decode use the current-cycle state. A source
    // completing this cycle is INFLIGHT, so it can never be selected now.
    always_comb begin
        eligible     = '0;
        complete_hit = '0;
        sel_id       = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            eligible[i]     = (state_q[i] == GW_PENDING) && int_enable[i];
            complete_hit[i] = complete_valid && (complete_id == ID_W'(i + 1));
        end
        // Scan downwards so that the lowest eligible index is the last one written.
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                sel_id = ID_W'(i + 1);
            end
        end
    end

    // Gateway next state. IDLE only looks at the level, so a source that
    // completes with its level still high spends one cycle in IDLE first.
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            state_d[i] = state_q[i];
            case (state_q[i])
                GW_IDLE: begin
                    if (s_lvl[i]) begin
                        state_d[i] = GW_PENDING;
                    end
                end
                GW_PENDING: begin
                    if (claim_req && (sel_id == ID_W'(i + 1))) begin
                        state_d[i] = GW_INFLIGHT;
                    end
                end
                GW_INFLIGHT: begin
                    if (complete_hit[i]) begin
                        state_d[i] = GW_IDLE;
                    end
                end
                default: state_d[i] = GW_IDLE;
            endcase
        end
        // irq follows the present pending set, so it drops one cycle after
        // the claim that removes the last eligible source.
        irq_d        = |eligible;
        resp_valid_d = claim_req;
        resp_id_d    = claim_req ? sel_id : resp_id_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                state_q[i] <= GW_IDLE;
            end
            irq_q        <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                state_q[i] <= state_d[i];
            end
            irq_q        <= irq_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
        end
    end

    always_comb begin
        dbg_state = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            dbg_state[2*i +: 2] = state_q[i];
        end
    end

    assign irq_out          = irq_q;
    assign claim_resp_valid = resp_valid_q;
    assign claim_resp_id    = resp_id_q;

endmodule

// File: tb/tb_int_gateway_claim.sv
// Bench for int_gateway_claim at its default parameters (5 sources, 2 sync
// stages, 3-bit IDs). Expected claim IDs go into exp_q when a claim is driven
// and are compared when the response pulse appears. A cycle model that follows
// the behavioural description tracks irq_out and the response outputs.
module tb_int_gateway_claim;

    localparam int NS = 5;

    logic          clock;
    logic          reset;
    logic [NS-1:0] int_in;
    logic [NS-1:0] int_enable;
    logic          irq_out;
    logic          claim_req;
    logic          claim_resp_valid;
    logic [2:0]    claim_resp_id;
    logic          complete_valid;
    logic [2:0]    complete_id;
    logic [2*NS-1:0] dbg_state;

    int_gateway_claim #(.NUM_SRC(NS), .SYNC_STAGES(2), .ID_W(3)) dut (
        .clock            (clock),
        .reset            (reset),
        .int_in           (int_in),
        .int_enable       (int_enable),
        .irq_out          (irq_out),
        .claim_req        (claim_req),
        .claim_resp_valid (claim_resp_valid),
        .claim_resp_id    (claim_resp_id),
        .complete_valid   (complete_valid),
        .complete_id      (complete_id),
        .dbg_state        (dbg_state)
    );

    // Clock and reset block
    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;
    logic [2:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model. State codes: 0 idle, 1 pending, 2 in flight.
    int         m_st [NS];
    logic [NS-1:0] m_s1, m_s2;
    logic       m_irq, m_rv;
    logic [2:0] m_rid;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_s1 = '0; m_s2 = '0; m_irq = 0; m_rv = 0; m_rid = 0;
            for (int i = 0; i < NS; i++) m_st[i] = 0;
        end else begin
            int   sel;
            logic any;
            sel = -1;
            any = 0;
            for (int i = 0; i < NS; i++) begin
                if (m_st[i] == 1 && int_enable[i]) begin
                    any = 1;
                    if (sel < 0) sel = i;
                end
            end
            for (int i = 0; i < NS; i++) begin
                if (m_st[i] == 0) begin
                    if (m_s2[i]) m_st[i] = 1;
                end else if (m_st[i] == 1) begin
                    if (claim_req && sel == i) m_st[i] = 2;
                end else begin
                    if (complete_valid && complete_id == 3'(i + 1)) m_st[i] = 0;
                end
            end
            m_rv = claim_req;
            if (claim_req) m_rid = (sel < 0) ? 3'd0 : 3'(sel + 1);
            m_irq = any;
            m_s2 = m_s1;
            m_s1 = int_in;
        end
    end

    function automatic logic [2:0] pred_id();
        for (int i = 0; i < NS; i++) begin
            if (m_st[i] == 1 && int_enable[i]) return 3'(i + 1);
        end
        return 3'd0;
    endfunction

    // Scoreboard: outputs are sampled on the falling edge.
    always @(negedge clock) begin
        if (!reset) begin
            check("irq_model", irq_out, m_irq);
            check("resp_valid_model", claim_resp_valid, m_rv);
            check("resp_id_hold", claim_resp_id, m_rid);
            if (claim_resp_valid) begin
                if (exp_q.size() == 0) begin
                    check("resp_unexpected", 1, 0);
                end else begin
                    logic [2:0] e;
                    e = exp_q.pop_front();
                    check("claim_id", claim_resp_id, e);
                end
            end
        end
    end

    // Driver tasks: all drive on the falling edge.
    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic do_claim(input logic [2:0] exp);
        claim_req = 1'b1;
        exp_q.push_back(exp);
        @(negedge clock);
        claim_req = 1'b0;
    endtask

    task automatic do_complete(input logic [2:0] id);
        complete_valid = 1'b1;
        complete_id    = id;
        @(negedge clock);
        complete_valid = 1'b0;
        complete_id    = 3'd0;
    endtask

    task automatic do_claim_complete(input logic [2:0] exp, input logic [2:0] id);
        claim_req      = 1'b1;
        complete_valid = 1'b1;
        complete_id    = id;
        exp_q.push_back(exp);
        @(negedge clock);
        claim_req      = 1'b0;
        complete_valid = 1'b0;
        complete_id    = 3'd0;
    endtask

    initial begin
        reset = 1'b1;
        int_in = '0; int_enable = '1;
        claim_req = 0; complete_valid = 0; complete_id = 0;
        tick(2);
        check("rst_irq", irq_out, 0);
        check("rst_resp_valid", claim_resp_valid, 0);
        check("rst_resp_id", claim_resp_id, 0);
        check("rst_dbg_state", dbg_state, 0);
        reset = 1'b0;
        tick(1);

        // 1: latency of four edges, claim ID 3, irq drops afterwards
        int_in = 5'b00100;
        tick(3);
        check("t1_irq_early", irq_out, 0);
        tick(1);
        check("t1_irq_lat4", irq_out, 1);
        do_claim(3'd3);
        tick(1);
        check("t1_irq_drop", irq_out, 0);
        int_in = '0;
        tick(3);
        do_complete(3'd3);

        // 2: back-to-back claims, then a re-pend after completion
        int_in = 5'b10010;
        tick(4);
        claim_req = 1'b1; exp_q.push_back(3'd2);
        tick(1);          exp_q.push_back(3'd5);
        tick(1);          exp_q.push_back(3'd0);
        tick(1);
        claim_req = 1'b0;
        do_complete(3'd2);
        check("t2_irq_idle", irq_out, 0);
        tick(1);
        check("t2_irq_repend1", irq_out, 0);
        tick(1);
        check("t2_irq_repend2", irq_out, 1);
        int_in = '0;
        tick(3);
        do_complete(3'd5);
        do_claim(3'd2);
        do_complete(3'd2);
        tick(2);

        // 3: short pulse is latched
        int_in = 5'b00001;
        tick(2);
        int_in = '0;
        tick(3);
        check("t3_irq_latched", irq_out, 1);
        do_claim(3'd1);
        do_complete(3'd1);
        tick(3);
        check("t3_irq_clear", irq_out, 0);

        // 4: a disabled source is hidden until re-enabled
        int_in = 5'b01000; int_enable = 5'b10111;
        tick(5);
        check("t4_irq_masked", irq_out, 0);
        do_claim(3'd0);
        int_enable = '1;
        tick(1);
        check("t4_irq_unmasked", irq_out, 1);
        do_claim(3'd4);
        int_in = '0;
        tick(3);
        do_complete(3'd4);

        // 5: ignored completes; simultaneous claim and complete
        int_in = 5'b00100;
        tick(4);
        do_claim(3'd3);
        do_complete(3'd0);
        do_complete(3'd7);
        do_complete(3'd1);
        tick(2);
        do_claim(3'd0);
        int_in = 5'b00101;
        tick(4);
        do_claim_complete(3'd1, 3'd3);
        tick(1);
        do_claim(3'd3);
        int_in = '0;
        tick(3);
        do_complete(3'd1);
        do_complete(3'd3);
        tick(2);

        // 6: reset with a source in flight and a claim outstanding
        int_in = 5'b00010;
        tick(4);
        do_claim(3'd2);
        tick(1);
        claim_req = 1'b1;
        #2 reset = 1'b1;
        #1;
        check("t6_irq", irq_out, 0);
        check("t6_resp_valid", claim_resp_valid, 0);
        check("t6_resp_id", claim_resp_id, 0);
        check("t6_dbg_state", dbg_state, 0);
        @(negedge clock);
        claim_req = 1'b0;
        @(negedge clock);
        check("t6_no_resp", claim_resp_valid, 0);
        reset = 1'b0;
        tick(3);
        check("t6_irq_pre", irq_out, 0);
        tick(1);
        check("t6_irq_repend", irq_out, 1);
        do_claim(3'd2);
        int_in = '0;
        tick(3);
        do_complete(3'd2);

        // Random traffic with model-predicted claim IDs
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 3) == 0) int_in = NS'($urandom_range(0, 31));
            if ($urandom_range(0, 5) == 0) int_enable = NS'($urandom_range(0, 31));
            claim_req      = ($urandom_range(0, 2) == 0);
            complete_valid = ($urandom_range(0, 2) == 0);
            complete_id    = 3'($urandom_range(0, 7));
            if (claim_req) exp_q.push_back(pred_id());
            @(negedge clock);
        end
        claim_req = 0; complete_valid = 0; complete_id = 0;
        tick(3);
        check("queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
